iob_async_req_arb: RTL

Round-robin arbiter that shares one downstream resource among N_REQ requesters whose request lines are asynchronous to clk_i. Every request line passes through a 2-flop synchronizer and rising-edge detector. Each detected edge becomes one pending event. Pending events are issued one at a time as a registered grant with a valid/ready handshake. It sits between free-running or foreign-domain event sources (timers, GPIO, peripheral interrupts) and a single-consumer service block.

---
 rtl/iob_async_req_arb_pkg.sv | 30 +++
 rtl/iob_sync_edge.sv | 35 +++
 rtl/iob_async_req_arb.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/iob_async_req_arb_pkg.sv
// Shared definitions for the asynchronous-request round-robin arbiter:
// the grant index width derivation, grant FSM state encodings and reset values.
package iob_async_req_arb_pkg;

  // Number of bits needed to index n requesters (ceil(log2(n))).
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Grant FSM: IDLE has no grant outstanding, GRANT presents gnt_id_o.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Reset values for the state, grant-valid and synchronizer flops.
  localparam arb_state_e RST_STATE     = ST_IDLE;
  localparam logic       RST_GNT_VALID = 1'b0;
  localparam logic       RST_SYNC_BIT  = 1'b0;

endpackage : iob_async_req_arb_pkg

// File: rtl/iob_sync_edge.sv
// N_REQ-wide two-flop synchronizer followed by a history flop. A rising
// edge on a synchronized request line produces a one-cycle pulse on edge_o.
// All flops reset to 0, so a line already high at reset release yields one
// edge pulse.
module iob_sync_edge
  import iob_async_req_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] edge_o
);

  logic [N_REQ-1:0] s1_r;
  logic [N_REQ-1:0] s2_r;
  logic [N_REQ-1:0] s3_r;

  // Synchronize the asynchronous request lines and keep one cycle of history.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s1_r <= {N_REQ{RST_SYNC_BIT}};
      s2_r <= {N_REQ{RST_SYNC_BIT}};
      s3_r <= {N_REQ{RST_SYNC_BIT}};
    end else begin
      s1_r <= req_i;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign edge_o = s2_r & ~s3_r;

endmodule : iob_sync_edge

// File: rtl/iob_async_req_arb.sv
// Round-robin arbiter for asynchronous event requesters. Each synchronized
// rising edge becomes one pending event; pending events are issued one at a
// time as a registered grant with a valid/ready handshake and no bubble
// between back-to-back grants.
// Optional feature macro: IOB_ASYNC_REQ_ARB_OVERFLOW_EN builds sticky
// per-requester overflow flags; without it overflow_o is tied to 0.
module iob_async_req_arb
  import iob_async_req_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2_f(N_REQ)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             clr_i,
  input  logic [N_REQ-1:0] req_i,
  output logic             gnt_valid_o,
  output logic [ID_W-1:0]  gnt_id_o,
  input  logic             gnt_ready_i,
  output logic [N_REQ-1:0] pending_o,
  output logic [N_REQ-1:0] overflow_o
);

  localparam int SUM_W = ID_W + 1;

  logic [N_REQ-1:0] edge_s;
  logic [N_REQ-1:0] pending_r;
  logic [N_REQ-1:0] consume_s;
  logic             pick_found_s;
  logic [ID_W-1:0]  pick_id_s;
  logic [ID_W-1:0]  next_ptr_s;
  logic [SUM_W-1:0] sum_s;
  logic             load_en_s;
  logic             grant_load_s;
  arb_state_e       state_r;
  logic             gnt_valid_r;
  logic [ID_W-1:0]  gnt_id_r;
  logic [ID_W-1:0]  ptr_r;

  iob_sync_edge #(
    .N_REQ (N_REQ)
  ) u_sync_edge (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .req_i    (req_i),
    .edge_o   (edge_s)
  );

  // Round-robin search over pending events starting at the pointer, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    sum_s        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s = {1'b0, ptr_r} + SUM_W'(k);
      if (sum_s >= SUM_W'(N_REQ)) begin
        sum_s = sum_s - SUM_W'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      if (!pick_found_s && pending_r[sum_s[ID_W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_id_s    = sum_s[ID_W-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // A new grant may load when idle or on the handshake of the current grant.
  always_comb begin
    load_en_s = 1'b0;
    case (state_r)
      ST_IDLE:  load_en_s = 1'b1;
      ST_GRANT: load_en_s = gnt_ready_i;
      default:  load_en_s = 1'b0;
    endcase
  end

  assign grant_load_s = load_en_s & pick_found_s;

  // One-hot of the pending bit consumed by a grant load, and the next pointer.
  always_comb begin
    consume_s  = '0;
    next_ptr_s = '0;
    if (grant_load_s) begin
      consume_s[pick_id_s] = 1'b1;
    end else begin
      consume_s = '0;
    end
    if (int'(pick_id_s) == (N_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = pick_id_s + ID_W'(1);
    end
  end

  // Pending bitmap: edges set bits, grant loads clear them; a new edge on the
  // bit being consumed keeps it set.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pending_r <= '0;
    end else if (clr_i) begin
      pending_r <= '0;
    end else begin
      pending_r <= (pending_r & ~consume_s) | edge_s;
    end
  end

  // Grant FSM with registered valid, id and round-robin pointer.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r     <= RST_STATE;
      gnt_valid_r <= RST_GNT_VALID;
      gnt_id_r    <= '0;
      ptr_r       <= '0;
    end else if (clr_i) begin
      state_r     <= RST_STATE;
      gnt_valid_r <= RST_GNT_VALID;
      gnt_id_r    <= '0;
      ptr_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_load_s) begin
            state_r     <= ST_GRANT;
            gnt_valid_r <= 1'b1;
            gnt_id_r    <= pick_id_s;
            ptr_r       <= next_ptr_s;
          end
        end
        ST_GRANT: begin
          if (grant_load_s) begin
            gnt_valid_r <= 1'b1;
            gnt_id_r    <= pick_id_s;
            ptr_r       <= next_ptr_s;
          end else if (gnt_ready_i) begin
            state_r     <= ST_IDLE;
            gnt_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef IOB_ASYNC_REQ_ARB_OVERFLOW_EN
  logic [N_REQ-1:0] overflow_r;
  logic [N_REQ-1:0] ovf_hit_s;

  // An edge landing on a pending bit that is not being consumed is lost.
  assign ovf_hit_s = edge_s & pending_r & ~consume_s;

  // Sticky overflow flags, cleared only by clr_i or reset.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      overflow_r <= '0;
    end else if (clr_i) begin
      overflow_r <= '0;
    end else begin
      overflow_r <= overflow_r | ovf_hit_s;
    end
  end

  assign overflow_o = overflow_r;
`else
  assign overflow_o = '0;
`endif

  assign gnt_valid_o = gnt_valid_r;
  assign gnt_id_o    = gnt_id_r;
  assign pending_o   = pending_r;

endmodule : iob_async_req_arb
